if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction-fetch stage shared types and the instruction-memory bus.
// The package carries the IF/ID register layout; the interface bundles
// the fetch request/response handshake.
package if_stage_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_flow_t;
endpackage

interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the instruction-memory handshake, keeps
// the PC, parks a word in a skid buffer when the pipe stalls on a completed
// fetch, and abandons in-flight fetches on a redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output if_id_flow_t     outflow,
  output logic            out_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_en,
  input  logic [31:0]     redirect_pc,
  if_stage_if.master      imem
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_buf;
  logic [31:0] drop_addr;   // address of the request abandoned by a redirect
  logic [31:0] target;
  logic [31:0] pc_next;
  logic        freeze;      // stall that is not overridden by a flush

  // Derived control: aligned redirect target, wrapping increment, freeze.
  always_comb begin
    target  = {redirect_pc[31:2], 2'b00};
    pc_next = pc + 32'd4;
    freeze  = stall & ~flush;
  end

  // Memory request: idle while the word sits in the skid buffer or in reset;
  // the abandoned address is held until the memory completes it.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    if (reset) begin
      imem.imem_req = 1'b0;
    end else if (state == HOLD) begin
      imem.imem_req = 1'b0;
    end else begin
      imem.imem_req = 1'b1;
    end
    if (state == DROP) begin
      imem.imem_addr = drop_addr;
    end else begin
      imem.imem_addr = pc;
    end
  end

  // Fetch FSM, PC, skid buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      skid_buf  <= 32'h0000_0000;
      drop_addr <= RESET_PC;
      outflow   <= '{pc: RESET_PC, instr: NOP_INSTR};
      out_valid <= 1'b0;
    end else if (redirect_en) begin
      pc        <= target;
      outflow   <= '{pc: target, instr: NOP_INSTR};
      out_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (imem.imem_ready) begin
            state <= FETCH;
          end else begin
            state     <= DROP;
            drop_addr <= pc;
          end
        end
        HOLD:    state <= FETCH;
        // A completing abandoned request ends the drop even under redirect.
        DROP:    state <= imem.imem_ready ? FETCH : DROP;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_ready) begin
            if (freeze) begin
              skid_buf <= imem.imem_rdata;
              state    <= HOLD;
            end else begin
              pc            <= pc_next;
              outflow.pc    <= pc;
              outflow.instr <= flush ? NOP_INSTR : imem.imem_rdata;
              out_valid     <= ~flush;
            end
          end else if (!freeze) begin
            outflow   <= '{pc: pc, instr: NOP_INSTR};
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!freeze) begin
            pc            <= pc_next;
            outflow.pc    <= pc;
            outflow.instr <= flush ? NOP_INSTR : skid_buf;
            out_valid     <= ~flush;
            state         <= FETCH;
          end
        end
        DROP: begin
          if (imem.imem_ready) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
